// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types, instruction field positions and the opcode-class
// step table for the 19-bit CPU control unit.
package cpu_ctrl_pkg;

    // 19-bit instruction format: [18:14] opcode, [13:10] dst, [9:6] src, [5:0] imm
    localparam int unsigned INSTR_W    = 19;
    localparam int unsigned OPCODE_W   = 5;
    localparam int unsigned REG_SEL_W  = 4;
    localparam int unsigned IMM_W      = 6;
    localparam int unsigned OPCODE_MSB = 18;
    localparam int unsigned DST_MSB    = 13;
    localparam int unsigned SRC_MSB    = 9;
    localparam int unsigned IMM_MSB    = 5;
    localparam int unsigned STEP_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HALT = 2'd2
    } seq_state_t;

    // Opcode class lives in opcode[4:3]
    localparam logic [1:0] CLS_ALU    = 2'b00;
    localparam logic [1:0] CLS_MEM    = 2'b01;
    localparam logic [1:0] CLS_BRANCH = 2'b10;
    localparam logic [1:0] CLS_SYS    = 2'b11;

    localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11111;

    localparam logic [STEP_CNT_W-1:0] STEPS_ALU    = 4'd3;
    localparam logic [STEP_CNT_W-1:0] STEPS_MEM    = 4'd5;
    localparam logic [STEP_CNT_W-1:0] STEPS_BRANCH = 4'd2;
    localparam logic [STEP_CNT_W-1:0] STEPS_SYS    = 4'd1;

    // Number of execution steps for an opcode, chosen by its class
    function automatic logic [STEP_CNT_W-1:0] steps_for_opcode(input logic [OPCODE_W-1:0] opcode);
        logic [STEP_CNT_W-1:0] n;
        case (opcode[OPCODE_W-1 -: 2])
            CLS_ALU:    n = STEPS_ALU;
            CLS_MEM:    n = STEPS_MEM;
            CLS_BRANCH: n = STEPS_BRANCH;
            default:    n = STEPS_SYS;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/instr_step_sequencer_step_counter.sv
// step_counter: loadable micro-step counter with hold, clear and a
// terminal-count compare against the latched last step index.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   load_i          - restart at step 0 with last index last_idx_i
//   last_idx_i      - final step index (count - 1) for the new instruction
//   inc_i           - advance one step (deasserted = hold)
//   clear_i         - return to step 0, last index 0 (has priority over load)
//   step_o          - current step
//   terminal_c      - step_o equals the latched last index
module step_counter #(
    parameter int unsigned STEP_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [STEP_W-1:0] last_idx_i,
    input  logic              inc_i,
    input  logic              clear_i,
    output logic [STEP_W-1:0] step_o,
    output logic              terminal_c
);

    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] last_q, last_d;

    // Next-count selection: clear > load > increment > hold
    always_comb begin
        step_d = step_q;
        last_d = last_q;
        if (clear_i) begin
            step_d = '0;
            last_d = '0;
        end else if (load_i) begin
            step_d = '0;
            last_d = last_idx_i;
        end else if (inc_i) begin
            step_d = step_q + STEP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= '0;
            last_q <= '0;
        end else begin
            step_q <= step_d;
            last_q <= last_d;
        end
    end

    assign step_o     = step_q;
    assign terminal_c = (step_q == last_q);

endmodule

// File: rtl/instr_step_sequencer.sv
// instr_step_sequencer: control-unit front stage. Accepts one instruction over
// valid/ready, registers its fields and walks a micro-step counter through the
// number of steps its opcode class needs.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   instr_in, instr_valid       - instruction word and its valid
//   instr_ready                 - instruction can be accepted this cycle
//   stall                       - hold the current step
//   flush                       - abort the current instruction
//   opcode, dst_sel, src_sel, imm - registered instruction fields
//   step, step_valid, last_step - micro-step index, valid in EXEC, final step
//   halted                      - in HALT state
module instr_step_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned IW     = 19,
    parameter int unsigned OPW    = 5,
    parameter int unsigned RSW    = 4,
    parameter int unsigned STEP_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IW-1:0]     instr_in,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              stall,
    input  logic              flush,
    output logic [OPW-1:0]    opcode,
    output logic [RSW-1:0]    dst_sel,
    output logic [RSW-1:0]    src_sel,
    output logic [5:0]        imm,
    output logic [STEP_W-1:0] step,
    output logic              step_valid,
    output logic              last_step,
    output logic              halted
);

    seq_state_t        state_q, state_d;
    logic [OPW-1:0]    opcode_q, opcode_d;
    logic [RSW-1:0]    dst_q, dst_d;
    logic [RSW-1:0]    src_q, src_d;
    logic [5:0]        imm_q, imm_d;

    logic              cnt_load, cnt_inc, cnt_clear, cnt_terminal;
    logic [STEP_W-1:0] cnt_step;
    logic [STEP_W-1:0] new_last_idx;
    logic [OPW-1:0]    new_opcode;
    logic              accept;

    assign new_opcode   = instr_in[IW-1 -: OPW];
    assign new_last_idx = STEP_W'(steps_for_opcode(5'(new_opcode)) - 4'd1);

    // Ready depends only on state, counter and stall/flush, never on instr_in
    assign instr_ready = ~rst & ((state_q == IDLE) |
                                 ((state_q == EXEC) & cnt_terminal & ~stall & ~flush));
    assign accept      = instr_valid & instr_ready;

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        dst_d     = dst_q;
        src_d     = src_q;
        imm_d     = imm_q;
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;
        cnt_clear = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_load = 1'b1;
                    state_d  = (new_opcode == OPW'(OP_HALT)) ? HALT : EXEC;
                end
            end
            EXEC: begin
                if (flush) begin
                    state_d   = IDLE;
                    cnt_clear = 1'b1;
                    opcode_d  = '0;
                    dst_d     = '0;
                    src_d     = '0;
                    imm_d     = '0;
                end else if (!stall) begin
                    if (!cnt_terminal) begin
                        cnt_inc = 1'b1;
                    end else if (accept) begin
                        // back-to-back restart, no bubble
                        cnt_load = 1'b1;
                        state_d  = (new_opcode == OPW'(OP_HALT)) ? HALT : EXEC;
                    end else begin
                        state_d   = IDLE;
                        cnt_clear = 1'b1;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d   = IDLE;
                cnt_clear = 1'b1;
            end
        endcase

        // accept only ever coincides with a load
        if (cnt_load) begin
            opcode_d = new_opcode;
            dst_d    = instr_in[IW-OPW-1 -: RSW];
            src_d    = instr_in[IW-OPW-RSW-1 -: RSW];
            imm_d    = instr_in[5:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            dst_q    <= '0;
            src_q    <= '0;
            imm_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            dst_q    <= dst_d;
            src_q    <= src_d;
            imm_q    <= imm_d;
        end
    end

    step_counter #(
        .STEP_W (STEP_W)
    ) u_step_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .last_idx_i (new_last_idx),
        .inc_i      (cnt_inc),
        .clear_i    (cnt_clear),
        .step_o     (cnt_step),
        .terminal_c (cnt_terminal)
    );

    assign opcode     = opcode_q;
    assign dst_sel    = dst_q;
    assign src_sel    = src_q;
    assign imm        = imm_q;
    assign step       = cnt_step;
    assign step_valid = (state_q == EXEC);
    assign last_step  = (state_q == EXEC) & cnt_terminal;
    assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_instr_step_sequencer.sv
// Directed bench for instr_step_sequencer with hand-computed expectations.
module tb_instr_step_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        stall;
    logic        flush;
    logic [4:0]  opcode;
    logic [3:0]  dst_sel;
    logic [3:0]  src_sel;
    logic [5:0]  imm;
    logic [2:0]  step;
    logic        step_valid;
    logic        last_step;
    logic        halted;

    int checks = 0;
    int errors = 0;

    localparam logic [18:0] I_ALU  = 19'b00010_0011_0101_000111;
    localparam logic [18:0] I_MEM  = 19'b01000_0001_0010_101010;
    localparam logic [18:0] I_BR   = 19'b10000_0110_0111_000001;
    localparam logic [18:0] I_SYS  = 19'b11000_1001_1010_111111;
    localparam logic [18:0] I_HALT = 19'b11111_0000_0000_000000;

    always #5 clk = ~clk;

    instr_step_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .stall       (stall),
        .flush       (flush),
        .opcode      (opcode),
        .dst_sel     (dst_sel),
        .src_sel     (src_sel),
        .imm         (imm),
        .step        (step),
        .step_valid  (step_valid),
        .last_step   (last_step),
        .halted      (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check step/step_valid/last_step/ready together
    task automatic check_step(input string tag, input logic [2:0] s, input logic v,
                              input logic l, input logic r);
        check({tag, ".step"}, 32'(step), 32'(s));
        check({tag, ".valid"}, 32'(step_valid), 32'(v));
        check({tag, ".last"}, 32'(last_step), 32'(l));
        check({tag, ".ready"}, 32'(instr_ready), 32'(r));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".opcode"}, 32'(opcode), 32'd0);
        check({tag, ".dst"}, 32'(dst_sel), 32'd0);
        check({tag, ".src"}, 32'(src_sel), 32'd0);
        check({tag, ".imm"}, 32'(imm), 32'd0);
        check({tag, ".step"}, 32'(step), 32'd0);
        check({tag, ".valid"}, 32'(step_valid), 32'd0);
        check({tag, ".last"}, 32'(last_step), 32'd0);
        check({tag, ".halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        rst = 1'b1; instr_in = '0; instr_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        tick();
        tick();
        check_all_zero("rst");
        check("rst.ready", 32'(instr_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst.ready", 32'(instr_ready), 32'd1);

        // ALU: 3 steps, fields 2/3/5/7
        instr_in = I_ALU; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check_step("alu0", 3'd0, 1'b1, 1'b0, 1'b0);
        check("alu.opcode", 32'(opcode), 32'd2);
        check("alu.dst", 32'(dst_sel), 32'd3);
        check("alu.src", 32'(src_sel), 32'd5);
        check("alu.imm", 32'(imm), 32'd7);
        tick();
        check_step("alu1", 3'd1, 1'b1, 1'b0, 1'b0);
        tick();
        check_step("alu2", 3'd2, 1'b1, 1'b1, 1'b1);
        tick();
        check_step("alu_idle", 3'd0, 1'b0, 1'b0, 1'b1);

        // MEM: stall 3 cycles at step 2 -> 0,1,2,2,2,2,3,4 then stall at last step
        instr_in = I_MEM; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("mem.opcode", 32'(opcode), 32'd8);
        check("mem.imm", 32'(imm), 32'h2a);
        check_step("mem0", 3'd0, 1'b1, 1'b0, 1'b0);
        tick();
        check_step("mem1", 3'd1, 1'b1, 1'b0, 1'b0);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_step("mem2_stall", 3'd2, 1'b1, 1'b0, 1'b0);
            tick();
        end
        stall = 1'b0;
        check_step("mem2_go", 3'd2, 1'b1, 1'b0, 1'b0);
        tick();
        check_step("mem3", 3'd3, 1'b1, 1'b0, 1'b0);
        tick();
        check_step("mem4", 3'd4, 1'b1, 1'b1, 1'b1);
        stall = 1'b1;
        #1;
        check("mem4_stall.ready", 32'(instr_ready), 32'd0);
        tick();
        check_step("mem4_held", 3'd4, 1'b1, 1'b1, 1'b0);
        check("mem4_held.opcode", 32'(opcode), 32'd8);
        stall = 1'b0;
        tick();
        check_step("mem_idle", 3'd0, 1'b0, 1'b0, 1'b1);

        // Back-to-back BRANCH then SYS with valid held
        instr_in = I_BR; instr_valid = 1'b1;
        tick();
        instr_in = I_SYS;
        #1;
        check_step("br0", 3'd0, 1'b1, 1'b0, 1'b0);
        check("br.opcode", 32'(opcode), 32'd16);
        tick();
        check_step("br1", 3'd1, 1'b1, 1'b1, 1'b1);
        check("br1.opcode", 32'(opcode), 32'd16);
        tick();
        instr_valid = 1'b0;
        #1;
        check_step("sys0", 3'd0, 1'b1, 1'b1, 1'b1);
        check("sys.opcode", 32'(opcode), 32'd24);
        check("sys.dst", 32'(dst_sel), 32'd9);
        check("sys.src", 32'(src_sel), 32'd10);
        tick();
        check_step("sys_idle", 3'd0, 1'b0, 1'b0, 1'b1);

        // Flush at MEM step 1 with stall and a pending valid instruction
        instr_in = I_MEM; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        check_step("fl_mem1", 3'd1, 1'b1, 1'b0, 1'b0);
        flush = 1'b1; stall = 1'b1; instr_valid = 1'b1; instr_in = I_ALU;
        #1;
        check("fl.ready", 32'(instr_ready), 32'd0);
        tick();
        flush = 1'b0; stall = 1'b0; instr_valid = 1'b0;
        #1;
        check_all_zero("flushed");
        check("flushed.ready", 32'(instr_ready), 32'd1);
        tick();
        check("flushed2.valid", 32'(step_valid), 32'd0);
        check("flushed2.opcode", 32'(opcode), 32'd0);

        // HALT: sticky until reset, ignores valid and flush
        instr_in = I_HALT; instr_valid = 1'b1;
        tick();
        instr_in = I_ALU;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            #1;
            check("halt.halted", 32'(halted), 32'd1);
            check("halt.ready", 32'(instr_ready), 32'd0);
            check("halt.valid", 32'(step_valid), 32'd0);
            check("halt.opcode", 32'(opcode), 32'd31);
            tick();
        end
        instr_valid = 1'b0; flush = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("halt_rst.halted", 32'(halted), 32'd0);
        check("halt_rst.ready", 32'(instr_ready), 32'd1);

        // Reset at MEM step 3
        instr_in = I_MEM; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        tick();
        check_step("rm_mem3", 3'd3, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        check_all_zero("rst_mid");
        check("rst_mid.ready", 32'(instr_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_mid_rel.ready", 32'(instr_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_step_sequencer.md
# instr_step_sequencer

Control-unit front stage of the 19-bit CPU. It accepts one 19-bit instruction over a valid/ready handshake and splits it into opcode, register-select and immediate fields. It then walks a micro-step counter through the number of execution steps that the opcode class requires. Its `step` output drives the 3-to-8 `Deco_NX2PN` that generates the one-hot T-state lines, and `dst_sel`/`src_sel` drive the 4-to-16 `Deco_NX2PN` instances that generate the register-file enables.

## Interface
- `IW`, default 19: instruction width.
- `OPW`, default 5: opcode width, taken from `instr[18:14]`.
- `RSW`, default 4: register-select width. `dst` is `instr[13:10]`, `src` is `instr[9:6]`.
- `STEP_W`, default 3: step counter width, so at most 8 steps.
- `clk`, input, 1: single clock. All state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `instr_in`, input, IW: instruction word.
- `instr_valid`, input, 1: `instr_in` is valid.
- `instr_ready`, output, 1: the block can accept an instruction this cycle.
- `stall`, input, 1: hold the current step (memory busy).
- `flush`, input, 1: abort the current instruction (branch taken).
- `opcode`, output, OPW: registered opcode.
- `dst_sel`, output, RSW: registered destination register index.
- `src_sel`, output, RSW: registered source register index.
- `imm`, output, 6: registered `instr[5:0]`.
- `step`, output, STEP_W: current micro-step index. Feeds the T-state decoder.
- `step_valid`, output, 1: `step` is meaningful (state EXEC).
- `last_step`, output, 1: the current step is the final one for this opcode.
- `halted`, output, 1: the block is in state HALT.

## Operation
- States:
  - IDLE: waits for an instruction.
  - EXEC: steps through the micro-steps.
  - HALT: terminal.
- Step count by `opcode[4:3]`:
  - 00 ALU: 3 steps.
  - 01 MEM: 5 steps.
  - 10 BRANCH: 2 steps.
  - 11 SYS: 1 step.
  - Exception: `5'b11111` is HALT.
- `instr_ready` = (IDLE) OR (EXEC AND `last_step` AND NOT `stall` AND NOT `flush`). It is 0 in HALT and 0 while `rst` is high.
- Accept occurs on `instr_valid & instr_ready` at a clock edge:
  - Fields are latched.
  - The step count is latched.
  - `step` goes to 0.
  - The next state is EXEC, or HALT for opcode `5'b11111`.
- EXEC, no stall, step < count-1: `step` increments by 1.
- EXEC, no stall, step = count-1:
  - With a concurrent accept, restart at step 0 with the new fields (back-to-back, no bubble).
  - Otherwise go to IDLE.
- `stall` in EXEC: `step`, the fields and the state hold. `instr_ready` is 0 while stalled in the last step.
- `flush` in EXEC:
  - Next state is IDLE, `step` is 0, and the fields are cleared to 0.
  - `flush` overrides `stall` and any concurrent accept. The new instruction is not taken.
  - `flush` is ignored in IDLE and HALT.
- HALT: `halted`=1 and `step_valid`=0. Only `rst` exits HALT.
- The counter never wraps; the count is always ≤ 8. Behaviour is undefined if STEP_W is too small for the table.

## Timing
- Reset (`rst` high at an edge): state is IDLE. `opcode`, `dst_sel`, `src_sel`, `imm`, `step`, `step_valid`, `last_step` and `halted` are all 0. `instr_ready` is 1 in the first cycle after `rst` deasserts.
- Reset mid-EXEC or in HALT: return to IDLE within one edge. No partial step is retained.
- Latency: the instruction accepted at edge k produces `step_valid`=1, `step`=0 and valid fields in cycle k+1.
- An unstalled N-step instruction occupies cycles k+1 through k+N.
- `last_step` and `step_valid` are combinational from registered state. There is no combinational path from `instr_in` to any output except `instr_ready`, which has no path from `instr_in` at all.

## Structure
- Package `cpu_ctrl_pkg`:
  - State enum `seq_state_t` {IDLE, EXEC, HALT}.
  - Opcode class constants.
  - `OP_HALT` = `5'b11111`.
  - Function `steps_for_opcode(opcode)` returning the step count.
  - Field-position localparams for the 19-bit format.
- Natural sub-module: `step_counter`, a loadable STEP_W counter with hold (stall), clear and terminal-count compare. The FSM and field registers stay in the top module.

## Test plan
- Reset then ALU `instr_in=19'b00010_0011_0101_000111`, valid 1 cycle → cycles 1-3: `step`=0,1,2. `dst_sel`=3, `src_sel`=5, `imm`=7. `last_step` is set at step 2, then the block returns to IDLE.
- MEM instruction with `stall` high during step 2 for 3 cycles → `step` holds at 2 for 3 cycles, 5 steps complete, 8 cycles total.
- Back-to-back: BRANCH, then SYS presented with valid held → steps 0,1 then 0. No idle cycle between them. `instr_ready`=1 only in the branch's step 1.
- `flush` at MEM step 1, concurrent with `stall` and `instr_valid` → next cycle is IDLE, `step_valid`=0, fields are 0, and the new instruction is not consumed.
- HALT opcode `5'b11111` accepted → `halted`=1 and `instr_ready`=0 indefinitely. `rst` pulse → IDLE, `instr_ready`=1.
- `rst` asserted mid-MEM step 3 → all outputs are 0 on the next cycle.
